// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared state encodings and default timing constants for the LED sequencer
package led_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_UNLOCK   = 3'd1,
        ST_FAIL_ON  = 3'd2,
        ST_FAIL_OFF = 3'd3,
        ST_ALARM    = 3'd4
    } state_t;

    localparam int DEF_TICK_DIV    = 1_000_000;
    localparam int DEF_ON_TICKS    = 200;
    localparam int DEF_BLINK_TICKS = 25;
    localparam int DEF_FAIL_BLINKS = 3;
    localparam int DEF_ALARM_TICKS = 10;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk into one-cycle timing ticks, restartable by clr
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    assign tick = r_cnt == LAST;

    // count up to DIV-1 then wrap; clr realigns the tick grid to a state entry
    always_ff @(posedge clk) begin
        r_cnt <= (!rst_n || clr || tick) ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: door-lock LED sequencer arbitrating unlock, fail-blink and alarm events
module led_seq_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int ON_TICKS    = DEF_ON_TICKS,
    parameter int BLINK_TICKS = DEF_BLINK_TICKS,
    parameter int FAIL_BLINKS = DEF_FAIL_BLINKS,
    parameter int ALARM_TICKS = DEF_ALARM_TICKS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_unlock,
    input  logic               req_fail,
    input  logic               alarm_set,
    input  logic               alarm_clr,
    output logic               led_in,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] state_o
);

    localparam int MAXT_A = (ON_TICKS > BLINK_TICKS) ? ON_TICKS : BLINK_TICKS;
    localparam int MAXT   = (MAXT_A > ALARM_TICKS) ? MAXT_A : ALARM_TICKS;
    localparam int PH_W   = $clog2(MAXT + 1);
    localparam int BL_W   = $clog2(FAIL_BLINKS + 1);
    localparam logic [PH_W-1:0] ON_LAST = PH_W'(ON_TICKS - 1);
    localparam logic [PH_W-1:0] BK_LAST = PH_W'(BLINK_TICKS - 1);
    localparam logic [PH_W-1:0] AL_LAST = PH_W'(ALARM_TICKS - 1);
    localparam logic [BL_W-1:0] FB_LAST = BL_W'(FAIL_BLINKS - 1);

    state_t          r_state;
    logic            r_led;
    logic            r_busy;
    logic            r_done;
    logic [PH_W-1:0] r_phase;
    logic [BL_W-1:0] r_blink;
    state_t          w_next;
    logic            w_tick;
    logic            w_pdone;
    logic            w_clr;

    tick_prescaler #(.DIV(TICK_DIV)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    // next-state arbitration; alarm_set overrides everything, including alarm_clr
    always_comb begin
        w_pdone = w_tick && r_phase == (r_state == ST_UNLOCK ? ON_LAST :
                                        r_state == ST_ALARM  ? AL_LAST : BK_LAST);
        w_next  = r_state;
        case (r_state)
            ST_IDLE:     w_next = req_fail ? ST_FAIL_ON : req_unlock ? ST_UNLOCK : ST_IDLE;
            ST_UNLOCK:   w_next = w_pdone ? ST_IDLE : ST_UNLOCK;
            ST_FAIL_ON:  w_next = w_pdone ? ST_FAIL_OFF : ST_FAIL_ON;
            ST_FAIL_OFF: w_next = !w_pdone ? ST_FAIL_OFF : (r_blink == FB_LAST) ? ST_IDLE : ST_FAIL_ON;
            ST_ALARM:    w_next = alarm_clr ? ST_IDLE : ST_ALARM;
            default:     w_next = ST_IDLE;
        endcase
        if (alarm_set) w_next = ST_ALARM;
        w_clr = (w_next != r_state) || r_state == ST_IDLE;
    end

    // state, counters and registered outputs all follow the chosen next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_led   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_phase <= '0;
            r_blink <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_next != ST_IDLE;
            r_done  <= w_next == ST_IDLE && r_state != ST_IDLE;
            r_phase <= (w_clr || w_pdone) ? '0 : w_tick ? r_phase + 1'b1 : r_phase;
            r_blink <= (w_next == ST_FAIL_ON && r_state == ST_FAIL_OFF) ? r_blink + 1'b1 :
                       (w_next == ST_FAIL_ON || w_next == ST_FAIL_OFF) ? r_blink : '0;
            r_led   <= (w_next == ST_UNLOCK || w_next == ST_FAIL_ON) ||
                       (w_next == ST_ALARM && (r_state != ST_ALARM || (r_led ^ w_pdone)));
        end
    end

    assign led_in  = r_led;
    assign busy    = r_busy;
    assign done    = r_done;
    assign state_o = r_state;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed checks of the LED sequencer with small timing parameters
module tb_led_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_unlock = 1'b0;
    logic       req_fail = 1'b0;
    logic       alarm_set = 1'b0;
    logic       alarm_clr = 1'b0;
    logic       led_in;
    logic       busy;
    logic       done;
    logic [2:0] state_o;
    int         n_pass = 0;
    int         n_tot = 0;

    led_seq_ctrl #(
        .TICK_DIV    (4),
        .ON_TICKS    (3),
        .BLINK_TICKS (2),
        .FAIL_BLINKS (3),
        .ALARM_TICKS (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_unlock (req_unlock),
        .req_fail   (req_fail),
        .alarm_set  (alarm_set),
        .alarm_clr  (alarm_clr),
        .led_in     (led_in),
        .busy       (busy),
        .done       (done),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // inputs change and outputs are sampled on the falling edge
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_tot++;
        if ({led_in, busy, done, state_o} !== 6'b000_000)
            $display("FAIL reset: got led=%b busy=%b done=%b st=%0d want all 0", led_in, busy, done, state_o);
        else n_pass++;
        rst_n = 1'b1;
        step();
        n_tot++;
        if ({led_in, busy, done, state_o} !== 6'b000_000)
            $display("FAIL reset_release: got led=%b busy=%b done=%b st=%0d want all 0", led_in, busy, done, state_o);
        else n_pass++;
    endtask

    task automatic test_unlock();
        req_unlock = 1'b1;
        step();
        req_unlock = 1'b0;
        for (int k = 0; k < 12; k++) begin
            n_tot++;
            if ({led_in, busy, done, state_o} !== {3'b110, 3'd1})
                $display("FAIL unlock_hold[%0d]: got led=%b busy=%b done=%b st=%0d want 1 1 0 1", k, led_in, busy, done, state_o);
            else n_pass++;
            step();
        end
        n_tot++;
        if ({led_in, busy, done, state_o} !== {3'b001, 3'd0})
            $display("FAIL unlock_done: got led=%b busy=%b done=%b st=%0d want 0 0 1 0", led_in, busy, done, state_o);
        else n_pass++;
        step();
        n_tot++;
        if (done !== 1'b0)
            $display("FAIL unlock_done_pulse: got done=%b want 0", done);
        else n_pass++;
    endtask

    task automatic test_fail(input logic with_unlock, input int unlock_at);
        logic       exp_led;
        logic [2:0] exp_st;
        req_fail = 1'b1;
        req_unlock = with_unlock;
        step();
        req_fail = 1'b0;
        req_unlock = 1'b0;
        for (int k = 0; k < 48; k++) begin
            exp_led = ((k / 8) % 2) == 0;
            exp_st  = exp_led ? 3'd2 : 3'd3;
            n_tot++;
            if ({led_in, busy, done, state_o} !== {exp_led, 2'b10, exp_st})
                $display("FAIL fail_seq[%0d]: got led=%b busy=%b done=%b st=%0d want %b 1 0 %0d", k, led_in, busy, done, state_o, exp_led, exp_st);
            else n_pass++;
            req_unlock = (k == unlock_at);
            step();
            req_unlock = 1'b0;
        end
        n_tot++;
        if ({led_in, busy, done, state_o} !== {3'b001, 3'd0})
            $display("FAIL fail_done: got led=%b busy=%b done=%b st=%0d want 0 0 1 0", led_in, busy, done, state_o);
        else n_pass++;
        step();
        n_tot++;
        if ({done, state_o} !== {1'b0, 3'd0})
            $display("FAIL fail_after: got done=%b st=%0d want 0 0", done, state_o);
        else n_pass++;
    endtask

    task automatic test_alarm_preempt();
        logic exp_led;
        req_unlock = 1'b1;
        step();
        req_unlock = 1'b0;
        repeat (4) step();
        alarm_set = 1'b1;
        step();
        alarm_set = 1'b0;
        for (int j = 0; j < 12; j++) begin
            exp_led = ((j / 4) % 2) == 0;
            n_tot++;
            if ({led_in, busy, done, state_o} !== {exp_led, 2'b10, 3'd4})
                $display("FAIL alarm_blink[%0d]: got led=%b busy=%b done=%b st=%0d want %b 1 0 4", j, led_in, busy, done, state_o, exp_led);
            else n_pass++;
            alarm_set = (j == 9);
            step();
            alarm_set = 1'b0;
        end
        alarm_clr = 1'b1;
        step();
        alarm_clr = 1'b0;
        n_tot++;
        if ({led_in, busy, done, state_o} !== {3'b001, 3'd0})
            $display("FAIL alarm_clr: got led=%b busy=%b done=%b st=%0d want 0 0 1 0", led_in, busy, done, state_o);
        else n_pass++;
        step();
        n_tot++;
        if (done !== 1'b0)
            $display("FAIL alarm_clr_pulse: got done=%b want 0", done);
        else n_pass++;
    endtask

    task automatic test_alarm_edges();
        alarm_clr = 1'b1;
        step();
        alarm_clr = 1'b0;
        n_tot++;
        if ({led_in, busy, done, state_o} !== 6'b000_000)
            $display("FAIL clr_in_idle: got led=%b busy=%b done=%b st=%0d want all 0", led_in, busy, done, state_o);
        else n_pass++;
        alarm_set = 1'b1;
        alarm_clr = 1'b1;
        step();
        alarm_set = 1'b0;
        alarm_clr = 1'b0;
        n_tot++;
        if ({led_in, busy, done, state_o} !== {3'b110, 3'd4})
            $display("FAIL set_clr_same: got led=%b busy=%b done=%b st=%0d want 1 1 0 4", led_in, busy, done, state_o);
        else n_pass++;
        repeat (5) step();
        n_tot++;
        if ({led_in, state_o} !== {1'b0, 3'd4})
            $display("FAIL alarm_toggle: got led=%b st=%0d want 0 4", led_in, state_o);
        else n_pass++;
        rst_n = 1'b0;
        step();
        n_tot++;
        if ({led_in, busy, done, state_o} !== 6'b000_000)
            $display("FAIL reset_mid_alarm: got led=%b busy=%b done=%b st=%0d want all 0", led_in, busy, done, state_o);
        else n_pass++;
        rst_n = 1'b1;
        step();
        n_tot++;
        if ({busy, done, state_o} !== 5'b00_000)
            $display("FAIL after_reset: got busy=%b done=%b st=%0d want 0 0 0", busy, done, state_o);
        else n_pass++;
    endtask

    initial begin
        step();
        test_reset();
        test_unlock();
        test_fail(1'b0, -1);
        test_fail(1'b1, 10);
        test_alarm_preempt();
        test_alarm_edges();
        test_unlock();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
